addsub_pipe: RTL and testbench

Registered, handshaked issue stage that feeds the team's 32-bit combinational `addsub` adder/subtractor and buffers its results. It accepts operation requests over a valid/ready interface and latches them into an operand register. It drives `addsub` from that register, keeps a 32-bit accumulator for running sums, and pushes result plus flags into a small output FIFO consumed over a second valid/ready interface.

---
 rtl/addsub_pkg.sv | 28 ++
 rtl/addsub.sv | 20 ++
 rtl/addsub_pipe.sv | 175 +++++++++++++++++
 tb/tb_addsub_pipe.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// ---------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the addsub issue stage: datapath width, operation
// encodings and the layout of one result entry held in the output FIFO.
// ---------------------------------------------------------------------------
package addsub_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [2:0] {
        OP_ADD     = 3'b000,
        OP_SUB     = 3'b001,
        OP_ACC_ADD = 3'b010,
        OP_ACC_SUB = 3'b011,
        OP_LOAD    = 3'b100
    } op_t;

    // One completed operation: result plus carry, overflow, zero and
    // illegal-opcode flags.
    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
        logic             z;
        logic             err;
    } result_t;

endpackage

// File: rtl/addsub.sv
// ---------------------------------------------------------------------------
// addsub
// Combinational 32-bit adder/subtractor, modulo 2^32.
// Ports:
//   a, b  in  operands
//   sub   in  1 = a - b, 0 = a + b
//   sum   out result
// ---------------------------------------------------------------------------
module addsub
    import addsub_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum
);

    assign sum = sub ? (a - b) : (a + b);

endmodule

// File: rtl/addsub_pipe.sv
// ---------------------------------------------------------------------------
// addsub_pipe
// Registered issue stage in front of the combinational addsub unit. Requests
// are latched into an operand register (S1), evaluated against the running
// accumulator where needed, and the result plus flags is pushed into a small
// output FIFO drained over a valid/ready interface.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        request handshake
//   in_op, in_a, in_b        operation code and operands
//   out_valid/out_ready      result handshake (FIFO head)
//   out_res, out_c, out_v,   result, carry (no-borrow on subtract),
//   out_z, out_err           signed overflow, zero, illegal opcode
// ---------------------------------------------------------------------------
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int OUT_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_c,
    output logic             out_v,
    output logic             out_z,
    output logic             out_err
);

    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(OUT_DEPTH);

    logic             s1_valid;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH-1:0] acc;

    result_t          fifo_mem [OUT_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic             xfer;
    logic             accept;
    logic             pop;
    logic             is_acc;
    logic             do_sub;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
    logic             acc_wr;
    result_t          entry;
    result_t          shown;

    // Space is judged on the count at the start of the cycle, so a pop on a
    // full FIFO only frees a slot for the following cycle. This also keeps
    // out_ready off the combinational path into in_ready.
    assign xfer     = s1_valid && (count < DEPTH);
    assign in_ready = !rst && (!s1_valid || xfer);
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    assign is_acc = (s1_op == OP_ACC_ADD) || (s1_op == OP_ACC_SUB);
    assign do_sub = s1_op[0];
    assign op_a   = is_acc ? acc : s1_a;
    assign b_eff  = do_sub ? ~s1_b : s1_b;

    addsub u_addsub (
        .a   (op_a),
        .b   (s1_b),
        .sub (do_sub),
        .sum (sum)
    );

    // Carry out of the MSB recovered from the sum: when the top operand bits
    // match, they alone decide the carry; otherwise the carry into bit 31
    // propagates, and that carry is the inverse of sum[31].
    assign carry = (op_a[WIDTH-1] & b_eff[WIDTH-1]) |
                   ((op_a[WIDTH-1] ^ b_eff[WIDTH-1]) & ~sum[WIDTH-1]);
    assign ovf   = (op_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                   (sum[WIDTH-1] != op_a[WIDTH-1]);

    // Build the entry for whatever S1 holds; illegal codes yield a zero
    // result with only err (and z) set, and leave the accumulator alone.
    always_comb begin
        entry  = '0;
        acc_wr = 1'b0;
        case (s1_op)
            OP_ADD, OP_SUB, OP_ACC_ADD, OP_ACC_SUB: begin
                entry.res = sum;
                entry.c   = carry;
                entry.v   = ovf;
                acc_wr    = is_acc;
            end
            OP_LOAD: begin
                entry.res = s1_b;
                acc_wr    = 1'b1;
            end
            default: begin
                entry.err = 1'b1;
            end
        endcase
        entry.z = (entry.res == '0);
    end

    // Operand register, accumulator and FIFO bookkeeping. The accumulator
    // only moves when its producing op leaves S1, so a following ACC op
    // already sees the new value on the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            acc      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_op    <= in_op;
                s1_a     <= in_a;
                s1_b     <= in_b;
            end else if (xfer) begin
                s1_valid <= 1'b0;
            end

            if (xfer && acc_wr) begin
                acc <= entry.res;
            end

            if (xfer) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case ({xfer, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (xfer) begin
            fifo_mem[wr_ptr] <= entry;
        end
    end

    // Outputs are forced to zero while the FIFO is empty so that reset and
    // idle present a clean all-zero head.
    assign out_valid = (count != '0);
    assign shown     = out_valid ? fifo_mem[rd_ptr] : '0;
    assign out_res   = shown.res;
    assign out_c     = shown.c;
    assign out_v     = shown.v;
    assign out_z     = shown.z;
    assign out_err   = shown.err;

endmodule

// File: tb/tb_addsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_addsub_pipe
// Self-checking bench for addsub_pipe (OUT_DEPTH = 2). A reference model
// computes each result with plain 33-bit arithmetic at accept time and
// tracks pipeline occupancy to predict in_ready / out_valid every cycle.
// ---------------------------------------------------------------------------
module tb_addsub_pipe;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic [31:0] in_a = 32'd0;
    logic [31:0] in_b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_res;
    logic        out_c;
    logic        out_v;
    logic        out_z;
    logic        out_err;

    int total = 0;
    int bad   = 0;

    // Reference state: accepted-but-unread results in order, whether S1 is
    // occupied, FIFO fill level and the accumulator.
    logic [35:0] q[$];
    logic        m_s1;
    int          m_n;
    logic [31:0] m_acc;

    always #5 clk = ~clk;

    addsub_pipe #(.OUT_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_c     (out_c),
        .out_v     (out_v),
        .out_z     (out_z),
        .out_err   (out_err)
    );

    // Expected {res, c, v, z, err} straight from the operation rules.
    task automatic refOp(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [35:0] r);
        logic [32:0] full;
        logic [31:0] x;
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        err;
        res = 32'd0; c = 1'b0; v = 1'b0; err = 1'b0;
        x = (op == 3'd2 || op == 3'd3) ? m_acc : a;
        case (op)
            3'd0, 3'd2: begin
                full = {1'b0, x} + {1'b0, b};
                res  = full[31:0];
                c    = full[32];
                v    = (x[31] == b[31]) && (res[31] != x[31]);
            end
            3'd1, 3'd3: begin
                res = x - b;
                c   = (x >= b);
                v   = (x[31] != b[31]) && (res[31] != x[31]);
            end
            3'd4: res = b;
            default: err = 1'b1;
        endcase
        if (op == 3'd2 || op == 3'd3 || op == 3'd4) m_acc = res;
        r = {res, c, v, (res == 32'd0), err};
    endtask

    task automatic checkVal(input string tag, input logic [35:0] got,
                            input logic [35:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Per-cycle comparison of the handshake outputs and the FIFO head.
    task automatic checkOutput(input string tag);
        logic exp_rdy;
        exp_rdy = !m_s1 || (m_n < DEPTH);
        checkVal({tag, ".in_ready"}, {35'd0, in_ready}, {35'd0, exp_rdy});
        checkVal({tag, ".out_valid"}, {35'd0, out_valid}, {35'd0, (m_n > 0)});
        if (m_n > 0)
            checkVal({tag, ".head"}, {out_res, out_c, out_v, out_z, out_err}, q[0]);
    endtask

    // Drive one cycle of inputs (from a negedge), advance the model at the
    // rising edge, then check at the following negedge.
    task automatic applyStimulus(input logic v, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic rdy, input string tag);
        logic        t;
        logic        p;
        logic        acc_ok;
        logic [35:0] r;
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = rdy;
        @(posedge clk);
        t      = m_s1 && (m_n < DEPTH);
        p      = (m_n > 0) && rdy;
        acc_ok = v && (!m_s1 || (m_n < DEPTH));
        if (p) void'(q.pop_front());
        if (acc_ok) begin
            refOp(op, a, b, r);
            q.push_back(r);
        end
        m_n  = m_n + (t ? 1 : 0) - (p ? 1 : 0);
        m_s1 = acc_ok || (m_s1 && !t);
        @(negedge clk);
        checkOutput(tag);
    endtask

    // Assert reset asynchronously, check the cleared outputs at once, then
    // release at a negedge and check in_ready comes up.
    task automatic doReset(input string tag);
        rst = 1'b1;
        #1;
        q.delete();
        m_s1 = 1'b0; m_n = 0; m_acc = 32'd0;
        checkVal({tag, ".rst_ready"}, {35'd0, in_ready}, 36'd0);
        checkVal({tag, ".rst_outs"},
                 {out_valid, out_res, out_c, out_v, out_z, out_err}, 37'd0);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput({tag, ".release"});
    endtask

    // One request into an empty pipeline, checked against a fixed value,
    // then popped.
    task automatic runSingle(input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [35:0] exp,
                             input string tag);
        applyStimulus(1'b1, op, a, b, 1'b1, {tag, ".issue"});
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, {tag, ".land"});
        checkVal({tag, ".const"}, {out_res, out_c, out_v, out_z, out_err}, exp);
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, {tag, ".pop"});
    endtask

    function automatic logic [31:0] pickVal();
        case ($urandom_range(0, 5))
            0: pickVal = 32'h0000_0000;
            1: pickVal = 32'hFFFF_FFFF;
            2: pickVal = 32'h8000_0000;
            3: pickVal = 32'h7FFF_FFFF;
            4: pickVal = 32'h0000_0001;
            default: pickVal = $urandom;
        endcase
    endfunction

    initial begin
        m_s1 = 1'b0; m_n = 0; m_acc = 32'd0;
        @(negedge clk);
        doReset("reset0");

        // Arithmetic corner cases.
        runSingle(3'd0, 32'hFFFF_FFFF, 32'h1, {32'h0, 1'b1, 1'b0, 1'b1, 1'b0}, "add_wrap");
        runSingle(3'd1, 32'd5, 32'd7, {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0}, "sub_borrow");
        runSingle(3'd1, 32'h8000_0000, 32'h1, {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0}, "sub_ovf");
        runSingle(3'd0, 32'h7FFF_FFFF, 32'h1, {32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0}, "add_ovf");

        // Back-to-back accumulator chain with no bubbles.
        applyStimulus(1'b1, 3'd4, 32'd0, 32'd10, 1'b1, "chain.load");
        applyStimulus(1'b1, 3'd2, 32'd0, 32'd5, 1'b1, "chain.acc_add");
        checkVal("chain.r0", {4'd0, out_res}, 36'd10);
        applyStimulus(1'b1, 3'd3, 32'd0, 32'd20, 1'b1, "chain.acc_sub");
        checkVal("chain.r1", {4'd0, out_res}, 36'd15);
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, "chain.drain");
        checkVal("chain.r2", {4'd0, out_res}, {4'd0, 32'hFFFF_FFFB});
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, "chain.idle");

        // Backpressure: stream ADDs with the consumer stalled, then release.
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 3'd0, 32'(i * 100), 32'd1, 1'b0, "bp.fill");
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, "bp.drain");

        // Illegal opcode between LOAD and ACC_ADD.
        runSingle(3'd4, 32'd0, 32'd4, {32'd4, 1'b0, 1'b0, 1'b0, 1'b0}, "ill.load");
        runSingle(3'd7, 32'd9, 32'd9, {32'd0, 1'b0, 1'b0, 1'b1, 1'b1}, "ill.op7");
        runSingle(3'd2, 32'd0, 32'd1, {32'd5, 1'b0, 1'b0, 1'b0, 1'b0}, "ill.acc");

        // Reset with S1 and FIFO occupied, then prove acc was cleared.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 3'd4, 32'd0, 32'd77, 1'b0, "mid.fill");
        doReset("midrst");
        runSingle(3'd2, 32'd0, 32'd3, {32'd3, 1'b0, 1'b0, 1'b0, 1'b0}, "mid.acc");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++)
            applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                          pickVal(), pickVal(), $urandom_range(0, 2) != 0, "rand");
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, "rand.drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
